frame_max16: RTL and testbench
==============================

# frame_max16

Streaming peak detector that sits directly downstream of the signed sample source used in the sort16Max benches, including the file-driven pattern reader. It consumes one signed sample per accepted cycle and groups samples into frames of FRAME_LEN. Per frame it reports the largest value with its index and the second-largest value with its index. Results are registered, pulse-qualified, and held until the next frame completes.

## Interface
- DATA_WIDTH, 10, sample width; two's-complement signed.
- FRAME_LEN, 16, samples per frame; power of two, 2..256.
- IDX_WIDTH, 4, index width; equals log2(FRAME_LEN).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  sample qualifier; no backpressure, every asserted cycle is accepted.
- in_data  in  DATA_WIDTH  signed sample.
- in_sof  in  1  start-of-frame; only meaningful when in_valid=1.
- out_valid  out  1  one-cycle pulse: results below are updated.
- max_val  out  DATA_WIDTH  signed largest sample of the frame.
- max_idx  out  IDX_WIDTH  position of max_val within the frame, 0-based.
- sec_val  out  DATA_WIDTH  signed second-largest sample.
- sec_idx  out  IDX_WIDTH  position of sec_val.
- frame_cnt  out  16  completed frames since reset; wraps 0xFFFF->0.
- abort  out  1  one-cycle pulse: a partial frame was discarded by in_sof.

## Operation
- Internal state: sample counter cnt (IDX_WIDTH bits), running registers run_max/run_midx/run_sec/run_sidx, and a flag sec_ok.
- sec_ok is set once the current frame has at least two samples.
- Each accepted sample carries index cnt. cnt increments per accepted sample and wraps to 0 after FRAME_LEN-1.
- First sample of a frame (cnt=0, or in_sof=1):
  - run_max<=in_data, run_midx<=0.
  - sec_ok<=0.
  - Running registers are loaded directly; they are never cleared first.
- Later samples:
  - If in_data > run_max (signed): the old max moves to sec, and the new sample becomes max.
  - Else if !sec_ok or in_data > run_sec: the sample becomes sec.
  - Otherwise no change.
- Ties: the earliest index wins. A value equal to max never displaces max; it may become sec. A value equal to sec never displaces sec.
- All comparisons are signed DATA_WIDTH. There is no widening and no arithmetic.
- Frame completion: when a sample is accepted with index FRAME_LEN-1, the output registers load the final results including that sample, out_valid pulses, and frame_cnt increments.
- in_sof with in_valid while cnt!=0:
  - The partial frame is dropped and abort pulses.
  - No out_valid is produced for the dropped frame.
  - The current sample becomes index 0 and cnt<=1.
- in_sof at cnt=0 is a normal frame start; abort is not asserted.
- in_sof with in_valid=0 is ignored.
- Gaps (in_valid=0) freeze all state and may occur anywhere in a frame.
- Outputs hold their last values between out_valid pulses.

## Timing
- Reset (rst_n=0 at a rising edge):
  - cnt=0 and sec_ok=0.
  - out_valid=0, abort=0.
  - max_val=0, max_idx=0, sec_val=0, sec_idx=0, frame_cnt=0.
  - Reset mid-frame discards the partial frame silently; abort is not asserted.
- Latency: the last sample of a frame is accepted at edge T; out_valid and the results are visible after edge T, i.e. 1 cycle.
- Back-to-back frames: the first sample of the next frame may arrive at edge T+1 with no bubble. This does not disturb the held outputs.
- abort is visible after the edge that accepts the offending in_sof sample.
- out_valid and abort never assert in the same cycle. With FRAME_LEN>=2, an in_sof sample cannot also be index FRAME_LEN-1.
- Throughput: 1 sample/cycle, sustained indefinitely.

## Test plan
- Ramp: reset, then 16 consecutive samples -8..7 with in_sof on the first -> one out_valid 1 cycle after the 16th. max_val=7/max_idx=15, sec_val=6/sec_idx=14, frame_cnt=1.
- Negative and ties: frame of all -512 except index 5=-3 and index 9=-3 -> max_val=-3/max_idx=5, sec_val=-3/sec_idx=9.
- Gaps: the ramp frame with in_valid deasserted for 3 cycles after samples 4 and 11 -> identical results. out_valid arrives 1 cycle after the 16th accepted sample.
- Abort: 7 samples, then in_sof with 16 samples of value 100 except index 2=200 -> abort pulses once. One out_valid with max_val=200/max_idx=2, sec_val=100/sec_idx=0, frame_cnt=1.
- Back-to-back: 3 frames with no gaps (frame maxima 1, 511, -1) -> 3 out_valid pulses exactly 16 cycles apart. Outputs hold between pulses, and frame_cnt ends at 3.
- Reset mid-frame: rst_n low for 1 edge after 10 samples, then a full ramp frame -> all outputs 0 during reset, no abort. Only the post-reset frame reports, with frame_cnt=1.

Source files
------------

// File: rtl/frame_max16.sv
`default_nettype none
// ============================================================================
// Module      : frame_max16
// Description : Streaming per-frame peak detector. Reports the largest and
//               second-largest signed samples of each frame with indices.
// Revision    : 1.0 - initial release
// ============================================================================

module frame_max16 #(
    parameter int DATA_WIDTH = 10,
    parameter int FRAME_LEN  = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_sof,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic        [IDX_WIDTH-1:0]  max_idx,
    output logic signed [DATA_WIDTH-1:0] sec_val,
    output logic        [IDX_WIDTH-1:0]  sec_idx,
    output logic        [15:0]           frame_cnt,
    output logic                         abort
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] c_IDX_ONE  = IDX_WIDTH'(1);

    // Frame control state
    logic [IDX_WIDTH-1:0]         r_cnt;
    logic                         r_sec_ok;

    // Running per-frame results
    logic signed [DATA_WIDTH-1:0] r_run_max;
    logic        [IDX_WIDTH-1:0]  r_run_midx;
    logic signed [DATA_WIDTH-1:0] r_run_sec;
    logic        [IDX_WIDTH-1:0]  r_run_sidx;

    // Held output registers
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_max_val;
    logic        [IDX_WIDTH-1:0]  r_max_idx;
    logic signed [DATA_WIDTH-1:0] r_sec_val;
    logic        [IDX_WIDTH-1:0]  r_sec_idx;
    logic        [15:0]           r_frame_cnt;
    logic                         r_abort;

    // Next-state view of the running registers including the current sample
    logic                         w_first;
    logic                         w_last;
    logic                         w_abort;
    logic        [IDX_WIDTH-1:0]  w_idx;
    logic signed [DATA_WIDTH-1:0] w_nmax;
    logic        [IDX_WIDTH-1:0]  w_nmidx;
    logic signed [DATA_WIDTH-1:0] w_nsec;
    logic        [IDX_WIDTH-1:0]  w_nsidx;
    logic                         w_nsec_ok;

    always_comb begin
        w_first   = in_sof || (r_cnt == '0);
        w_last    = !in_sof && (r_cnt == c_LAST_IDX);
        w_abort   = in_sof && (r_cnt != '0);
        w_idx     = in_sof ? '0 : r_cnt;
        w_nmax    = r_run_max;
        w_nmidx   = r_run_midx;
        w_nsec    = r_run_sec;
        w_nsidx   = r_run_sidx;
        w_nsec_ok = r_sec_ok;

        if (w_first) begin
            w_nmax    = in_data;
            w_nmidx   = '0;
            w_nsec_ok = 1'b0;
        end else if (in_data > r_run_max) begin
            // Strict compare keeps the earliest index on ties.
            w_nsec    = r_run_max;
            w_nsidx   = r_run_midx;
            w_nmax    = in_data;
            w_nmidx   = w_idx;
            w_nsec_ok = 1'b1;
        end else if (!r_sec_ok || (in_data > r_run_sec)) begin
            w_nsec    = in_data;
            w_nsidx   = w_idx;
            w_nsec_ok = 1'b1;
        end else begin
            w_nsec_ok = 1'b1;
        end
    end

    // Datapath registers are always overwritten by a frame's first sample.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_run_max  <= w_nmax;
            r_run_midx <= w_nmidx;
            r_run_sec  <= w_nsec;
            r_run_sidx <= w_nsidx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_sec_ok    <= 1'b0;
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
            r_max_val   <= '0;
            r_max_idx   <= '0;
            r_sec_val   <= '0;
            r_sec_idx   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
            if (in_valid) begin
                r_cnt    <= w_first ? c_IDX_ONE : r_cnt + c_IDX_ONE;
                r_sec_ok <= w_nsec_ok;
                r_abort  <= w_abort;
                if (w_last) begin
                    r_out_valid <= 1'b1;
                    r_max_val   <= w_nmax;
                    r_max_idx   <= w_nmidx;
                    r_sec_val   <= w_nsec;
                    r_sec_idx   <= w_nsidx;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign max_val   = r_max_val;
    assign max_idx   = r_max_idx;
    assign sec_val   = r_sec_val;
    assign sec_idx   = r_sec_idx;
    assign frame_cnt = r_frame_cnt;
    assign abort     = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_frame_max16.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_max16
// Description : Directed self-checking bench for frame_max16.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_frame_max16;

    localparam int DW = 10;
    localparam int IW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_sof;
    logic                 out_valid;
    logic signed [DW-1:0] max_val;
    logic        [IW-1:0] max_idx;
    logic signed [DW-1:0] sec_val;
    logic        [IW-1:0] sec_idx;
    logic        [15:0]   frame_cnt;
    logic                 abort;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;
    int ov_pulses = 0;
    int ab_pulses = 0;
    int ov_cyc[$];

    frame_max16 #(.DATA_WIDTH(DW), .FRAME_LEN(16), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .sec_val   (sec_val),
        .sec_idx   (sec_idx),
        .frame_cnt (frame_cnt),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_pulses = ov_pulses + 1;
            ov_cyc.push_back(cycle);
        end
        if (abort === 1'b1) ab_pulses = ab_pulses + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic sof);
        in_valid = 1'b1;
        in_data  = DW'(d);
        in_sof   = sof;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_res(input string tag, input int mv, input int mi,
                             input int sv, input int si, input int fc);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_max_val"}, max_val, mv);
        chk({tag, "_max_idx"}, max_idx, mi);
        chk({tag, "_sec_val"}, sec_val, sv);
        chk({tag, "_sec_idx"}, sec_idx, si);
        chk({tag, "_frame_cnt"}, frame_cnt, fc);
    endtask

    task automatic do_reset(input string tag, input int n);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_abort"}, abort, 0);
        chk({tag, "_max_val"}, max_val, 0);
        chk({tag, "_max_idx"}, max_idx, 0);
        chk({tag, "_sec_val"}, sec_val, 0);
        chk({tag, "_sec_idx"}, sec_idx, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int a0;
        int c0;
        int d;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;

        do_reset("reset", 2);

        // Ramp -8..7
        for (int i = 0; i < 16; i++) begin
            send(i - 8, i == 0);
            if (i == 14) chk("ramp_early", out_valid, 0);
        end
        check_res("ramp", 7, 15, 6, 14, 1);
        idle(1);
        chk("ramp_pulse_end", out_valid, 0);
        chk("ramp_hold", max_val, 7);

        // Negative values with ties
        for (int i = 0; i < 16; i++)
            send((i == 5 || i == 9) ? -3 : -512, i == 0);
        check_res("ties", -3, 5, -3, 9, 2);
        idle(1);

        // Ramp with gaps
        p0 = ov_pulses;
        for (int i = 0; i < 16; i++) begin
            send(i - 8, i == 0);
            if (i == 4 || i == 11) idle(3);
            if (i == 14) chk("gaps_early", out_valid, 0);
        end
        check_res("gaps", 7, 15, 6, 14, 3);
        idle(1);
        chk("gaps_pulses", ov_pulses - p0, 1);

        // Abort of a partial frame
        do_reset("reset2", 1);
        a0 = ab_pulses;
        p0 = ov_pulses;
        for (int i = 0; i < 7; i++) send(50, i == 0);
        chk("abort_pre", abort, 0);
        for (int i = 0; i < 16; i++) begin
            send((i == 2) ? 200 : 100, i == 0);
            if (i == 0) chk("abort_pulse", abort, 1);
            if (i == 1) chk("abort_clear", abort, 0);
        end
        check_res("abort", 200, 2, 100, 0, 1);
        idle(1);
        chk("abort_count", ab_pulses - a0, 1);
        chk("abort_ov_count", ov_pulses - p0, 1);

        // Three back-to-back frames
        do_reset("reset3", 1);
        p0 = ov_pulses;
        c0 = ov_cyc.size();
        for (int i = 0; i < 48; i++) begin
            case (i / 16)
                0:       d = ((i % 16) == 3) ? 1 : 0;
                1:       d = ((i % 16) == 0) ? 511 : (((i % 16) == 15) ? 300 : -100);
                default: d = -1;
            endcase
            send(d, (i % 16) == 0);
            if (i == 15) check_res("b2b_f0", 1, 3, 0, 0, 1);
            if (i == 21) begin
                chk("b2b_hold_ov", out_valid, 0);
                chk("b2b_hold_max", max_val, 1);
                chk("b2b_hold_cnt", frame_cnt, 1);
            end
            if (i == 31) check_res("b2b_f1", 511, 0, 300, 15, 2);
            if (i == 47) check_res("b2b_f2", -1, 0, -1, 1, 3);
        end
        idle(1);
        chk("b2b_pulses", ov_pulses - p0, 3);
        if (ov_cyc.size() >= c0 + 3) begin
            chk("b2b_gap01", ov_cyc[c0 + 1] - ov_cyc[c0], 16);
            chk("b2b_gap12", ov_cyc[c0 + 2] - ov_cyc[c0 + 1], 16);
        end else begin
            chk("b2b_pulse_log", ov_cyc.size() - c0, 3);
        end

        // Reset in the middle of a frame
        a0 = ab_pulses;
        p0 = ov_pulses;
        for (int i = 0; i < 10; i++) send(i * 7, i == 0);
        do_reset("rst_mid", 1);
        for (int i = 0; i < 16; i++) send(i - 8, i == 0);
        check_res("rst_mid_frame", 7, 15, 6, 14, 1);
        idle(1);
        chk("rst_mid_abort", ab_pulses - a0, 0);
        chk("rst_mid_pulses", ov_pulses - p0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
